// File: rtl/fx_pkg.sv
// Shared encodings for the note-effect blocks: mode field values and the glide FSM states.
package fx_pkg;

  localparam logic [1:0] FX_MODE_DOWN   = 2'b00;
  localparam logic [1:0] FX_MODE_UP     = 2'b01;
  localparam logic [1:0] FX_MODE_GLIDE  = 2'b10;
  localparam logic [1:0] FX_MODE_BYPASS = 2'b11;

  typedef enum logic [1:0] {
    FX_IDLE  = 2'd0,
    FX_SLIDE = 2'd1,
    FX_HOLD  = 2'd2
  } fx_state_t;

endpackage

// File: rtl/fx_tick_divider.sv
// Rate divider: counts qualifying ticks and fires step_en on every (speed+1)-th one.
// Intended for reuse by any rate-based note effect.
module fx_tick_divider
  import fx_pkg::*;
#(
  parameter int SPEED_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               tick,
  input  logic [SPEED_W-1:0] speed,
  output logic               step_en,
  output logic [SPEED_W-1:0] div_cnt
);

  // >= rather than == so a speed lowered below the running count steps on the next tick.
  assign step_en = tick & ~clear & (div_cnt >= speed);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= step_en ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fx_glide.sv
// Pitch slide/glide effect on the outgoing note. Define FX_GLIDE_WRAP_EN for the legacy
// wrapping behaviour of modes 00/01; by default those modes saturate and stop in HOLD.
module fx_glide
  import fx_pkg::*;
#(
  parameter int NOTE_W  = 6,
  parameter int SPEED_W = 2
) (
  input  logic               clk50mhz,
  input  logic               rst,
  input  logic               note_tick,
  input  logic               note_load,
  input  logic [NOTE_W-1:0]  note_in,
  input  logic [NOTE_W-1:0]  target,
  input  logic [1:0]         mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic               en,
  output logic [NOTE_W-1:0]  note_out,
  output logic               sliding,
  output logic               done,
  output fx_state_t          dbg_state,
  output logic [SPEED_W-1:0] dbg_div_cnt
);

  localparam logic [NOTE_W-1:0] NOTE_MAX = {NOTE_W{1'b1}};

  // note_tick and note_load are single-cycle strobes, counted once per high cycle; load beats tick.
  fx_state_t         state, state_nxt;
  logic [NOTE_W-1:0] note_nxt;
  logic              done_nxt;
  logic              bypass, step_en, step_up, at_stop;

  assign bypass = (mode == FX_MODE_BYPASS);

  fx_tick_divider #(.SPEED_W(SPEED_W)) u_div (
    .clk     (clk50mhz),
    .rst     (rst),
    .clear   (note_load | ~en | bypass),
    .tick    (note_tick & ~note_load & (state == FX_SLIDE)),
    .speed   (speed),
    .step_en (step_en),
    .div_cnt (dbg_div_cnt)
  );

  assign step_up = (mode == FX_MODE_UP) || ((mode == FX_MODE_GLIDE) && (target > note_out));

  always_comb begin
    at_stop = 1'b0;
    if (step_en) begin
      if (mode == FX_MODE_GLIDE) begin
        at_stop = (note_out == target);
      end else begin
`ifdef FX_GLIDE_WRAP_EN
        at_stop = 1'b0;
`else
        at_stop = step_up ? (note_out == NOTE_MAX) : (note_out == '0);
`endif
      end
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state    <= FX_IDLE;
      note_out <= '0;
      sliding  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      note_out <= note_nxt;
      sliding  <= (state_nxt == FX_SLIDE);
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bypass) begin
      state_nxt = FX_IDLE;
    end else if (note_load) begin
      state_nxt = en ? FX_SLIDE : FX_IDLE;
    end else if (at_stop) begin
      state_nxt = FX_HOLD;
    end
  end

  always_comb begin
    note_nxt = note_out;
    done_nxt = 1'b0;
    if (bypass || note_load) begin
      note_nxt = note_in;
    end else if (at_stop) begin
      done_nxt = 1'b1;
    end else if (step_en) begin
      note_nxt = step_up ? note_out + 1'b1 : note_out - 1'b1;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fx_glide.sv
// Self-checking bench for fx_glide: directed cases from the feature description followed by
// randomized traffic, all scored against a behavioural note model.
module tb_fx_glide;
  import fx_pkg::*;

  localparam int NOTE_W  = 6;
  localparam int SPEED_W = 2;
  localparam int NMAX    = (1 << NOTE_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               note_tick = 1'b0;
  logic               note_load = 1'b0;
  logic [NOTE_W-1:0]  note_in = '0;
  logic [NOTE_W-1:0]  target = '0;
  logic [1:0]         mode = 2'b01;
  logic [SPEED_W-1:0] speed = '0;
  logic               en = 1'b1;
  logic [NOTE_W-1:0]  note_out;
  logic               sliding;
  logic               done;
  fx_state_t          dbg_state;
  logic [SPEED_W-1:0] dbg_div_cnt;

  fx_glide #(.NOTE_W(NOTE_W), .SPEED_W(SPEED_W)) dut (
    .clk50mhz    (clk),
    .rst         (rst),
    .note_tick   (note_tick),
    .note_load   (note_load),
    .note_in     (note_in),
    .target      (target),
    .mode        (mode),
    .speed       (speed),
    .en          (en),
    .note_out    (note_out),
    .sliding     (sliding),
    .done        (done),
    .dbg_state   (dbg_state),
    .dbg_div_cnt (dbg_div_cnt)
  );

  always #10 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [NOTE_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 sliding, 2 holding; ticks counted since the last step.
  int m_note = 0, m_cnt = 0, m_st = 0;
  bit m_done = 0;

  task automatic model_take_step();
    bit stop;
    int nn;
    stop = 0;
    nn = m_note;
    case (mode)
      2'b01: if (m_note == NMAX) begin
`ifdef FX_GLIDE_WRAP_EN
               nn = 0;
`else
               stop = 1;
`endif
             end else nn = m_note + 1;
      2'b00: if (m_note == 0) begin
`ifdef FX_GLIDE_WRAP_EN
               nn = NMAX;
`else
               stop = 1;
`endif
             end else nn = m_note - 1;
      default: if (m_note == int'(target)) stop = 1;
               else nn = (int'(target) > m_note) ? m_note + 1 : m_note - 1;
    endcase
    if (stop) begin
      m_st = 2;
      m_done = 1;
    end else begin
      m_note = nn;
    end
  endtask

  task automatic model_update();
    m_done = 0;
    if (rst) begin
      m_note = 0; m_cnt = 0; m_st = 0;
    end else if (mode == 2'b11) begin
      m_note = note_in; m_st = 0; m_cnt = 0;
    end else if (note_load) begin
      m_note = note_in; m_cnt = 0;
      m_st = en ? 1 : 0;
    end else if (m_st == 1) begin
      if (!en) m_cnt = 0;
      else if (note_tick) begin
        if (m_cnt >= int'(speed)) begin
          m_cnt = 0;
          model_take_step();
        end else begin
          m_cnt++;
        end
      end
    end
    exp_q.push_back(m_note[NOTE_W-1:0]);
  endtask

  // One clock: the model consumes the inputs held across the edge, then outputs are scored.
  task automatic step();
    logic [NOTE_W-1:0] e;
    @(posedge clk);
    model_update();
    #1;
    e = exp_q.pop_front();
    check("note_out", note_out, e);
    check("sliding", sliding, (m_st == 1));
    check("done", done, m_done);
    check("state", dbg_state, m_st);
    if (m_st == 1) check("div_cnt", dbg_div_cnt, m_cnt);
  endtask

  task automatic load(input int n);
    note_in = n; note_load = 1'b1;
    step();
    note_load = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      note_tick = 1'b1; step();
      note_tick = 1'b0; step();
    end
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    check("rst_note", note_out, 0);
    check("rst_state", dbg_state, FX_IDLE);
    rst = 1'b0;
    step();

    // Slide up at half rate
    mode = 2'b01; speed = 2'd1; en = 1'b1;
    load(10);
    ticks(6);
    check("up_final", note_out, 13);
    check("up_sliding", sliding, 1);

    // Slide down into the floor
    mode = 2'b00; speed = 2'd0;
    load(2);
    ticks(4);
`ifdef FX_GLIDE_WRAP_EN
    check("down_final", note_out, 62);
    check("down_state", dbg_state, FX_SLIDE);
`else
    check("down_final", note_out, 0);
    check("down_state", dbg_state, FX_HOLD);
`endif

    // Glide toward target 5
    mode = 2'b10; target = 6'd5;
    load(8);
    ticks(6);
    check("glide_final", note_out, 5);
    check("glide_state", dbg_state, FX_HOLD);

    // Enable gap resets the divider
    mode = 2'b01; speed = 2'd3;
    load(30);
    ticks(1);
    en = 1'b0; ticks(5);
    en = 1'b1; ticks(3);
    check("en_nostep", note_out, 30);
    ticks(1);
    check("en_step", note_out, 31);

    // Load coincident with a tick
    ticks(2);
    note_tick = 1'b1;
    load(20);
    note_tick = 1'b0;
    check("ld_tick_note", note_out, 20);
    check("ld_tick_cnt", dbg_div_cnt, 0);

    // Reset mid-slide, then bypass tracking
    speed = 2'd0;
    load(37);
    ticks(3);
    check("pre_rst", note_out, 40);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_note", note_out, 0);
    check("mid_rst_slide", sliding, 0);
    check("mid_rst_state", dbg_state, FX_IDLE);
    mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      note_in = 6'(7 * i + 3);
      step();
      check("bypass_track", note_out, 7 * i + 3);
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 40 == 0) begin
        mode   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        speed  = 2'($urandom_range(0, 3));
        target = 6'($urandom_range(0, NMAX));
      end
      if ($urandom_range(0, 15) == 0) en = ~en;
      rst       = ($urandom_range(0, 299) == 0);
      note_load = ($urandom_range(0, 19) == 0);
      note_tick = ($urandom_range(0, 2) == 0);
      note_in   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 1) * NMAX)
                                               : 6'($urandom_range(0, NMAX));
      step();
    end
    rst = 1'b0; note_load = 1'b0; note_tick = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
